// File: rtl/shift_seq_ctrl_if.sv
// shift_seq_ctrl_if: request and result handshake bundle for shift_seq_ctrl.
// The master side issues requests and consumes results; the controller is the slave.
interface shift_seq_ctrl_if #(
    parameter int C_BIT_NUM = 24,
    parameter int C_CNT_W   = $clog2(C_BIT_NUM + 1)
);
    logic                 REQ_VALID;
    logic                 REQ_READY;
    logic [1:0]           REQ_OP;
    logic [C_CNT_W-1:0]   REQ_AMT;
    logic [C_BIT_NUM-1:0] REQ_DATA;
    logic                 RES_VALID;
    logic                 RES_READY;
    logic [C_BIT_NUM-1:0] RES_DATA;

    modport master (
        output REQ_VALID, REQ_OP, REQ_AMT, REQ_DATA, RES_READY,
        input  REQ_READY, RES_VALID, RES_DATA
    );

    modport slave (
        input  REQ_VALID, REQ_OP, REQ_AMT, REQ_DATA, RES_READY,
        output REQ_READY, RES_VALID, RES_DATA
    );
endinterface

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: loads an operand into univ_shift_reg and steps it one bit per cycle.
// Define SHIFT_SEQ_ABORT_EN to add the ABORT input.
module shift_seq_ctrl #(
    parameter int C_BIT_NUM = 24,
    parameter int C_CNT_W   = $clog2(C_BIT_NUM + 1)
) (
    input  logic                 CK,
    input  logic                 RST,
    shift_seq_ctrl_if.slave      bus,
    output logic                 BUSY,
    output logic                 SR_S0,
    output logic                 SR_S1,
    output logic                 SR_SLI,
    output logic                 SR_SRI,
    output logic [C_BIT_NUM-1:0] SR_D,
    input  logic [C_BIT_NUM-1:0] SR_Q
`ifdef SHIFT_SEQ_ABORT_EN
    ,
    input  logic                 ABORT
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_e;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    localparam logic [1:0] M_HOLD  = 2'b00;
    localparam logic [1:0] M_LEFT  = 2'b01;
    localparam logic [1:0] M_RIGHT = 2'b10;
    localparam logic [1:0] M_LOAD  = 2'b11;

    localparam logic [C_CNT_W-1:0] CNT_MAX = C_CNT_W'(C_BIT_NUM);
    localparam logic [C_CNT_W-1:0] CNT_ONE = C_CNT_W'(1);

    state_e               state;
    state_e               state_nx;
    logic [1:0]           op;
    logic [C_CNT_W-1:0]   cnt;
    logic [C_BIT_NUM-1:0] sr_d;
    logic [C_CNT_W-1:0]   amt_sat;
    logic [1:0]           mode;
    logic                 sri;
    logic                 req_ready;
    logic                 res_valid;
    logic                 busy;
    logic                 accept;
    logic                 abort_hit;

`ifdef SHIFT_SEQ_ABORT_EN
    assign abort_hit = ABORT && (state == LOAD || state == SHIFT);
`else
    assign abort_hit = 1'b0;
`endif

    assign amt_sat = (bus.REQ_AMT > CNT_MAX) ? CNT_MAX : bus.REQ_AMT;
    assign accept  = bus.REQ_VALID && req_ready;

    always_ff @(posedge CK) begin
        if (RST) begin
            state <= IDLE;
            op    <= OP_SLL;
            cnt   <= '0;
            sr_d  <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                op   <= bus.REQ_OP;
                cnt  <= amt_sat;
                sr_d <= bus.REQ_DATA;
            end else if (state == SHIFT) begin
                cnt <= cnt - CNT_ONE;
            end
        end
    end

    always_comb begin
        state_nx  = state;
        mode      = M_HOLD;
        sri       = 1'b0;
        req_ready = 1'b0;
        res_valid = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = !RST;
                if (bus.REQ_VALID && !RST) begin
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                busy     = 1'b1;
                mode     = M_LOAD;
                state_nx = (cnt != '0) ? SHIFT : DONE;
            end
            SHIFT: begin
                busy = 1'b1;
                mode = (op == OP_SLL) ? M_LEFT : M_RIGHT;
                unique case (op)
                    OP_SRA:  sri = SR_Q[C_BIT_NUM-1];
                    OP_ROR:  sri = SR_Q[0];
                    default: sri = 1'b0;
                endcase
                if (cnt == CNT_ONE) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                res_valid = 1'b1;
                if (bus.RES_READY) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        // An abort freezes the register in the same cycle it is seen.
        if (abort_hit) begin
            state_nx = IDLE;
            mode     = M_HOLD;
            sri      = 1'b0;
        end
    end

    assign bus.REQ_READY = req_ready;
    assign bus.RES_VALID = res_valid;
    assign bus.RES_DATA  = SR_Q;
    assign BUSY          = busy;
    assign SR_S1         = mode[1];
    assign SR_S0         = mode[0];
    assign SR_SLI        = 1'b0;
    assign SR_SRI        = sri;
    assign SR_D          = sr_d;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: scoreboard bench for shift_seq_ctrl driving a model of univ_shift_reg.
// Build with SHIFT_SEQ_ABORT_EN defined to cover the abort path too.
module tb_shift_seq_ctrl;

    localparam int N  = 8;
    localparam int CW = $clog2(N + 1);

    typedef struct {
        logic [N-1:0] data;
        int           acc;
        int           n;
    } exp_t;

    logic          CK;
    logic          RST;
    logic          BUSY;
    logic          SR_S0;
    logic          SR_S1;
    logic          SR_SLI;
    logic          SR_SRI;
    logic [N-1:0]  SR_D;
    logic [N-1:0]  sr_q = '0;
`ifdef SHIFT_SEQ_ABORT_EN
    logic          ABORT;
`endif

    shift_seq_ctrl_if #(.C_BIT_NUM(N)) bus ();

    shift_seq_ctrl #(.C_BIT_NUM(N)) dut (
        .CK     (CK),
        .RST    (RST),
        .bus    (bus),
        .BUSY   (BUSY),
        .SR_S0  (SR_S0),
        .SR_S1  (SR_S1),
        .SR_SLI (SR_SLI),
        .SR_SRI (SR_SRI),
        .SR_D   (SR_D),
        .SR_Q   (sr_q)
`ifdef SHIFT_SEQ_ABORT_EN
        ,
        .ABORT  (ABORT)
`endif
    );

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    bit   rr_force = 1'b0;
    bit   rr_val   = 1'b0;

    initial CK = 1'b0;
    always #5 CK = ~CK;
    always @(posedge CK) cyc <= cyc + 1;

    // Attached universal shift register: {S1,S0} 01 left, 10 right, 11 load.
    always @(posedge CK) begin
        case ({SR_S1, SR_S0})
            2'b01:   sr_q <= {sr_q[N-2:0], SR_SLI};
            2'b10:   sr_q <= {SR_SRI, sr_q[N-1:1]};
            2'b11:   sr_q <= SR_D;
            default: sr_q <= sr_q;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int clamp(input logic [CW-1:0] amt);
        return (int'(amt) > N) ? N : int'(amt);
    endfunction

    function automatic logic [N-1:0] ref_shift(input logic [1:0] op,
                                               input logic [N-1:0] d,
                                               input logic [CW-1:0] amt);
        int n;
        logic [N-1:0] r;
        n = clamp(amt);
        case (op)
            2'b00:   r = d << n;
            2'b01:   r = d >> n;
            2'b10:   r = $signed(d) >>> n;
            default: r = (d >> n) | (d << (N - n));
        endcase
        return r;
    endfunction

    // Result consumer: random backpressure unless forced.
    initial begin
        bus.RES_READY = 1'b0;
        forever begin
            @(posedge CK);
            #1;
            bus.RES_READY = rr_force ? rr_val : 1'($urandom_range(0, 1));
        end
    end

    // Monitor: latency on rising RES_VALID, stability while held, data on handshake.
    initial begin
        bit           prev_v;
        logic [N-1:0] held;
        exp_t         e;
        prev_v = 1'b0;
        held   = '0;
        forever begin
            @(negedge CK);
            if (RST) begin
                prev_v = 1'b0;
            end else begin
                if (bus.RES_VALID && !prev_v) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_res_valid", 1, 0);
                    end else begin
                        chk("res_latency", cyc - exp_q[0].acc, exp_q[0].n + 2);
                    end
                    held = bus.RES_DATA;
                end else if (bus.RES_VALID) begin
                    chk("res_data_stable", bus.RES_DATA, held);
                end
                if (bus.RES_VALID) begin
                    chk("req_ready_in_done", bus.REQ_READY, 0);
                end
                if (bus.RES_VALID && bus.RES_READY && exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("res_data", bus.RES_DATA, e.data);
                end
                prev_v = bus.RES_VALID;
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [N-1:0] d,
                        input logic [CW-1:0] amt);
        int w;
        @(negedge CK);
        bus.REQ_VALID = 1'b1;
        bus.REQ_OP    = op;
        bus.REQ_AMT   = amt;
        bus.REQ_DATA  = d;
        w = 0;
        while (!bus.REQ_READY && w < 300) begin
            @(negedge CK);
            w++;
        end
        if (!bus.REQ_READY) begin
            chk("accept_timeout", 1, 0);
            bus.REQ_VALID = 1'b0;
        end else begin
            exp_q.push_back('{ref_shift(op, d, amt), cyc, clamp(amt)});
            @(posedge CK);
            #1;
            bus.REQ_VALID = 1'b0;
            bus.REQ_DATA  = N'($urandom);
        end
    endtask

    // Register mode and status from LOAD through the first DONE cycle.
    task automatic follow(input logic [1:0] op, input logic [CW-1:0] amt);
        int n;
        logic [1:0] m;
        n = clamp(amt);
        for (int k = 0; k <= n + 1; k++) begin
            @(negedge CK);
            if (k == 0) m = 2'b11;
            else if (k <= n) m = (op == 2'b00) ? 2'b01 : 2'b10;
            else m = 2'b00;
            chk("sr_mode", {SR_S1, SR_S0}, m);
            chk("busy", BUSY, 1);
            chk("req_ready_busy", bus.REQ_READY, 0);
            chk("sli", SR_SLI, 0);
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 300) begin
            @(negedge CK);
            w++;
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic run(input logic [1:0] op, input logic [N-1:0] d,
                       input logic [CW-1:0] amt);
        send(op, d, amt);
        follow(op, amt);
        drain();
    endtask

    task automatic idle_checks(input string tag);
        chk({tag, "_busy"}, BUSY, 0);
        chk({tag, "_mode"}, {SR_S1, SR_S0}, 0);
        chk({tag, "_res_valid"}, bus.RES_VALID, 0);
        chk({tag, "_req_ready"}, bus.REQ_READY, 1);
    endtask

    initial begin
        RST           = 1'b1;
        bus.REQ_VALID = 1'b0;
        bus.REQ_OP    = 2'b00;
        bus.REQ_AMT   = '0;
        bus.REQ_DATA  = '0;
`ifdef SHIFT_SEQ_ABORT_EN
        ABORT = 1'b0;
`endif
        repeat (2) begin
            @(negedge CK);
            chk("req_ready_in_rst", bus.REQ_READY, 0);
        end
        @(posedge CK);
        #1;
        RST = 1'b0;
        @(negedge CK);
        idle_checks("reset");
        chk("reset_sr_d", SR_D, 0);
        chk("reset_sri", SR_SRI, 0);
        chk("reset_sli", SR_SLI, 0);

        run(2'b00, 8'h81, 4'd3);
        run(2'b10, 8'h90, 4'd2);
        run(2'b01, 8'h90, 4'd2);
        run(2'b11, 8'h01, 4'd1);
        run(2'b11, 8'hA5, 4'd12);
        run(2'b00, 8'hC3, 4'd8);
        run(2'b10, 8'h80, 4'd15);

        // Zero amount with the result held back for several cycles.
        rr_force = 1'b1;
        rr_val   = 1'b0;
        send(2'b01, 8'h5A, 4'd0);
        follow(2'b01, 4'd0);
        bus.REQ_VALID = 1'b1;
        bus.REQ_OP    = 2'b00;
        bus.REQ_AMT   = 4'd1;
        bus.REQ_DATA  = 8'hFF;
        repeat (5) begin
            @(negedge CK);
            chk("hold_req_ready", bus.REQ_READY, 0);
            chk("hold_res_valid", bus.RES_VALID, 1);
        end
        bus.REQ_VALID = 1'b0;
        rr_val = 1'b1;
        drain();
        rr_force = 1'b0;
        repeat (2) begin
            @(negedge CK);
            idle_checks("after_hold");
        end

        // Reset in the second shift cycle drops the request.
        send(2'b00, 8'h3C, 4'd5);
        @(negedge CK);
        @(negedge CK);
        @(negedge CK);
        chk("pre_rst_mode", {SR_S1, SR_S0}, 2'b01);
        RST = 1'b1;
        void'(exp_q.pop_back());
        @(posedge CK);
        #1;
        RST = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge CK);
            idle_checks("post_rst");
        end
        run(2'b10, 8'hB1, 4'd3);

`ifdef SHIFT_SEQ_ABORT_EN
        send(2'b01, 8'hE7, 4'd6);
        @(negedge CK);
        @(negedge CK);
        @(negedge CK);
        ABORT = 1'b1;
        void'(exp_q.pop_back());
        #1;
        chk("abort_mode_now", {SR_S1, SR_S0}, 0);
        @(posedge CK);
        #1;
        ABORT = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge CK);
            idle_checks("post_abort");
        end
        run(2'b11, 8'h96, 4'd3);
`endif

        for (int i = 0; i < 40; i++) begin
            logic [1:0]    op;
            logic [N-1:0]  d;
            logic [CW-1:0] amt;
            op  = 2'($urandom_range(0, 3));
            d   = N'($urandom);
            amt = CW'($urandom_range(0, 15));
            repeat ($urandom_range(0, 2)) @(negedge CK);
            run(op, d, amt);
        end

        @(negedge CK);
        idle_checks("final");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_seq_ctrl.md
# shift_seq_ctrl

Sequencer for the universal shift register (`univ_shift_reg`). It accepts a shift request over a valid/ready handshake and parallel-loads the operand into the register. It then steps the register one bit per cycle for the requested amount and presents the result on a valid/ready output. It owns the register's S0/S1/SLI/SRI/D controls and observes its Q, but never drives the register's reset.

## Interface
- C_BIT_NUM, 24: datapath width; must match the attached `univ_shift_reg`; minimum 2.
- C_CNT_W, $clog2(C_BIT_NUM+1): width of the shift amount and the internal counter.

- CK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset; synchronous, active-high.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  controller can accept a request.
- REQ_OP  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROR.
- REQ_AMT  in  C_CNT_W  shift amount.
- REQ_DATA  in  C_BIT_NUM  operand.
- RES_VALID  out  1  result available.
- RES_READY  in  1  result consumed.
- RES_DATA  out  C_BIT_NUM  result.
- BUSY  out  1  high in LOAD, SHIFT and DONE.
- SR_S0, SR_S1  out  1 each  register mode: 00 hold, 01 shift left (toward MSB, SLI enters bit 0), 10 shift right (toward LSB, SRI enters MSB), 11 parallel load.
- SR_SLI, SR_SRI  out  1 each  serial inputs to the register.
- SR_D  out  C_BIT_NUM  parallel-load data.
- SR_Q  in  C_BIT_NUM  register contents.
- ABORT  in  1  present only with SHIFT_SEQ_ABORT_EN.

## Operation
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - REQ_READY=1.
  - On REQ_VALID&&REQ_READY: latch REQ_OP; latch REQ_DATA into the SR_D register; load CNT=min(REQ_AMT, C_BIT_NUM); go to LOAD.
- LOAD:
  - Drive S=11 for one cycle.
  - Next state is SHIFT if CNT!=0, otherwise DONE.
- SHIFT:
  - Drive S=01 for SLL; S=10 for SRL, SRA and ROR.
  - Decrement CNT each cycle; go to DONE in the cycle where CNT==1.
- Serial-input values during SHIFT:
  - SLI=0 for all ops.
  - SRI=0 for SRL.
  - SRI=SR_Q[C_BIT_NUM-1] for SRA.
  - SRI=SR_Q[0] for ROR.
  - SRI=0 for SLL.
- DONE:
  - Drive S=00 (hold); RES_VALID=1; RES_DATA=SR_Q.
  - On RES_READY, go to IDLE.
- S=00 in IDLE and DONE.
- Saturation: an amount ≥ C_BIT_NUM saturates to C_BIT_NUM.
  - SLL and SRL produce 0.
  - SRA produces the sign fill.
  - ROR produces the original operand.
- No back-to-back requests: REQ_READY is low from the accept edge until the cycle after the RES handshake.
- RES_VALID, once high, stays high and RES_DATA stays stable until RES_READY.

## Timing
- Reset values: state IDLE; RES_VALID=0, BUSY=0, SR_S0=SR_S1=0, SR_SLI=SR_SRI=0, SR_D=0, CNT=0.
- REQ_READY=0 while RST=1.
- RES_DATA mirrors SR_Q; it is don't-care while RES_VALID=0.
- Latency from accept edge t:
  - LOAD occupies cycle t+1.
  - SHIFT occupies cycles t+2 .. t+1+n, where n is the clamped amount.
  - RES_VALID rises in cycle t+2+n; minimum 2 cycles, maximum C_BIT_NUM+2.
- REQ_VALID with REQ_READY=0 is ignored; the requester must hold the request.
- RES_READY in the cycle RES_VALID rises completes the transfer in that cycle; IDLE follows.
- RST asserted in any state:
  - IDLE and S=00 on the next edge; any result is dropped.
  - SR_Q contents are left as they are.
- RES_READY is ignored outside DONE.

## Configuration
- SHIFT_SEQ_ABORT_EN defined:
  - The ABORT port exists.
  - ABORT=1 in LOAD or SHIFT forces IDLE on the next edge, with S=00 from that cycle and no RES_VALID.
  - ABORT is ignored in IDLE and DONE.
- Undefined: the ABORT port is absent and every accepted request runs to DONE.

## Test plan
- C_BIT_NUM=8. Reset, then SLL REQ_DATA=0x81 AMT=3 → LOAD, 3 SHIFT cycles with S=01, RES_VALID at t+5, RES_DATA=0x08.
- SRA 0x90 AMT=2 → RES_DATA=0xE4. SRL 0x90 AMT=2 → RES_DATA=0x24.
- ROR 0x01 AMT=1 → RES_DATA=0x80. ROR 0xA5 AMT=12 → saturates to 8, RES_DATA=0xA5, RES_VALID at t+10.
- AMT=0 with 0x5A → RES_VALID at t+2, RES_DATA=0x5A. Hold RES_READY=0 for 5 cycles → data stable and REQ_READY=0; a second REQ_VALID is not accepted.
- RST pulsed in the second SHIFT cycle → next cycle IDLE, S=00, BUSY=0, no RES_VALID. A new request then completes normally.
- SHIFT_SEQ_ABORT_EN defined, ABORT during SHIFT → IDLE next cycle, RES_VALID never asserted.
